// File: rtl/ice40_pll_pkg.sv
// Shared types and sizing helpers for the iCE40 PLL supervisor and its sub-blocks.
package ice40_pll_pkg;

    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_WAIT   = 2'd1,
        ST_LOCKED = 2'd2,
        ST_FAIL   = 2'd3
    } pll_state_t;

    function automatic int unsigned retry_width(input int unsigned max_retries);
        return $clog2(max_retries + 2);
    endfunction

    function automatic int unsigned cnt_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/ice40_pll_supervisor_if.sv
// Supervisor <-> PLL/CRG signal bundle; master is the supervisor side.
interface ice40_pll_supervisor_if #(
    parameter int unsigned MAX_RETRIES = 7
);
    import ice40_pll_pkg::*;

    localparam int unsigned W = retry_width(MAX_RETRIES);

    logic         pll_lock_raw;
    logic         restart;
    logic         pll_resetb;
    logic         pll_lock;
    logic         lock_ok;
    logic         lock_lost;
    logic         fail;
    logic [W-1:0] retry_cnt;

    modport master (
        input  pll_lock_raw, restart,
        output pll_resetb, pll_lock, lock_ok, lock_lost, fail, retry_cnt
    );

    modport slave (
        output pll_lock_raw, restart,
        input  pll_resetb, pll_lock, lock_ok, lock_lost, fail, retry_cnt
    );

endinterface

// File: rtl/ice40_sync_ff.sv
// Generic single-bit synchroniser with asynchronous clear.
module ice40_sync_ff #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_sync <= '0;
        else     r_sync <= {r_sync[STAGES-2:0], i_d};
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/ice40_pll_supervisor.sv
// Sequences SB_PLL40 RESETB and qualifies its LOCK output for the serdes CRG.
module ice40_pll_supervisor
    import ice40_pll_pkg::*;
#(
    parameter int unsigned RST_CYCLES     = 16,
    parameter int unsigned STABLE_CYCLES  = 256,
    parameter int unsigned TIMEOUT_CYCLES = 65536,
    parameter int unsigned MAX_RETRIES    = 7,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    ice40_pll_supervisor_if.master   bus
);

    localparam int unsigned W  = retry_width(MAX_RETRIES);
    localparam int unsigned CW = cnt_width(RST_CYCLES, STABLE_CYCLES, TIMEOUT_CYCLES);

    localparam logic [CW-1:0] RST_LAST  = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] STAB_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] TMO_LAST  = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [W-1:0]  RETRY_MAX = W'(MAX_RETRIES);

    pll_state_t    r_state;
    pll_state_t    w_next;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_stab;
    logic [W-1:0]  r_retry;
    logic [W-1:0]  w_retry_next;
    logic          w_lock_s;
    logic          w_lost;
    logic          r_pll_resetb;
    logic          r_lock_ok;
    logic          r_pll_lock;
    logic          r_lock_lost;
    logic          r_fail;

    ice40_sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (bus.pll_lock_raw),
        .o_q (w_lock_s)
    );

    always_comb begin
        w_next       = r_state;
        w_retry_next = r_retry;
        w_lost       = 1'b0;
        if (bus.restart) begin
            w_next       = ST_RESET;
            w_retry_next = '0;
        end else begin
            case (r_state)
                ST_RESET: begin
                    if (r_cnt == RST_LAST) w_next = ST_WAIT;
                end
                ST_WAIT: begin
                    // stability is checked first so it wins a tie with the timeout
                    if (w_lock_s && (r_stab == STAB_LAST)) begin
                        w_next       = ST_LOCKED;
                        w_retry_next = '0;
                    end else if (r_cnt == TMO_LAST) begin
                        if (r_retry >= RETRY_MAX) begin
                            w_next = ST_FAIL;
                        end else begin
                            w_next       = ST_RESET;
                            w_retry_next = r_retry + 1'b1;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (!w_lock_s) begin
                        w_next = ST_RESET;
                        w_lost = 1'b1;
                    end
                end
                ST_FAIL: w_next = ST_FAIL;
                default: w_next = ST_RESET;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_RESET;
            r_cnt        <= '0;
            r_stab       <= '0;
            r_retry      <= '0;
            r_pll_resetb <= 1'b0;
            r_lock_ok    <= 1'b0;
            r_pll_lock   <= 1'b0;
            r_lock_lost  <= 1'b0;
            r_fail       <= 1'b0;
        end else begin
            r_state <= w_next;
            r_retry <= w_retry_next;

            // cnt only runs in the two timed states; restart forces a clear even without a state change
            if (bus.restart || (w_next != r_state) ||
                !((r_state == ST_RESET) || (r_state == ST_WAIT)))
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + 1'b1;

            if (!bus.restart && (r_state == ST_WAIT) && (w_next == ST_WAIT) && w_lock_s)
                r_stab <= r_stab + 1'b1;
            else
                r_stab <= '0;

            r_pll_resetb <= (w_next == ST_WAIT) || (w_next == ST_LOCKED);
            r_lock_ok    <= (w_next == ST_LOCKED);
            r_pll_lock   <= r_lock_ok;
            r_lock_lost  <= w_lost;
            r_fail       <= (w_next == ST_FAIL);
        end
    end

    assign bus.pll_resetb = r_pll_resetb;
    assign bus.lock_ok    = r_lock_ok;
    assign bus.pll_lock   = r_pll_lock;
    assign bus.lock_lost  = r_lock_lost;
    assign bus.fail       = r_fail;
    assign bus.retry_cnt  = r_retry;

endmodule
